// File: rtl/rr_arb9_ctrl.sv
// Round-robin arbiter for nine requesters sharing one cache datapath.
// Grants are held until done, request drop, or the hold budget runs out.
module rr_arb9_ctrl #(
  parameter int NREQ     = 9,
  parameter int MAX_HOLD = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_done,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_gnt_idx,
  output logic                    o_gnt_vld,
  output logic                    o_timeout
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nxtState;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    w_nxtGnt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_nxtIdx;
  logic               r_vld;
  logic               w_nxtVld;
  logic               r_timeout;
  logic               w_nxtTimeout;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_nxtPtr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nxtCnt;

  logic               w_ownDone;
  logic               w_ownReq;
  logic               w_atMax;
  logic               w_release;
  logic [IDX_W-1:0]   w_relPtr;
  logic [IDX_W-1:0]   w_arbPtr;
  logic [NREQ-1:0]    w_arbReq;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;

  // Abort and timeout mask the old owner out of the re-arbitration; done does not.
  always_comb begin
    w_ownDone = i_done[r_idx];
    w_ownReq  = i_req[r_idx];
    w_atMax   = (r_cnt == CNT_W'(MAX_HOLD - 1));
    w_release = (r_state == BUSY) && (w_ownDone || !w_ownReq || w_atMax);
    w_relPtr  = (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + IDX_W'(1);
    w_arbPtr  = r_ptr;
    w_arbReq  = i_req;
    if (w_release) begin
      w_arbPtr = w_relPtr;
      if (!w_ownDone) begin
        w_arbReq = i_req & ~(NREQ'(1) << r_idx);
      end
    end
  end

  always_comb begin
    int pos;
    w_found = 1'b0;
    w_win   = '0;
    pos     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(w_arbPtr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (!w_found && w_arbReq[pos]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    w_nxtState   = r_state;
    w_nxtGnt     = r_gnt;
    w_nxtIdx     = r_idx;
    w_nxtVld     = r_vld;
    w_nxtCnt     = r_cnt;
    w_nxtPtr     = r_ptr;
    w_nxtTimeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxtState = BUSY;
          w_nxtGnt   = NREQ'(1) << w_win;
          w_nxtIdx   = w_win;
          w_nxtVld   = 1'b1;
          w_nxtCnt   = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_nxtPtr     = w_relPtr;
          w_nxtTimeout = !w_ownDone && w_ownReq && w_atMax;
          w_nxtCnt     = '0;
          if (w_found) begin
            w_nxtGnt = NREQ'(1) << w_win;
            w_nxtIdx = w_win;
            w_nxtVld = 1'b1;
          end else begin
            w_nxtState = IDLE;
            w_nxtGnt   = '0;
            w_nxtIdx   = '0;
            w_nxtVld   = 1'b0;
          end
        end else begin
          w_nxtCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxtState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_nxtState;
      r_gnt     <= w_nxtGnt;
      r_idx     <= w_nxtIdx;
      r_vld     <= w_nxtVld;
      r_timeout <= w_nxtTimeout;
      r_ptr     <= w_nxtPtr;
      r_cnt     <= w_nxtCnt;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_idx = r_idx;
  assign o_gnt_vld = r_vld;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb9_ctrl.sv
// Directed bench for rr_arb9_ctrl: reset, rotation, wrap, abort, done vs. timeout.
module tb_rr_arb9_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic [8:0] i_req;
  logic [8:0] i_done;
  logic [8:0] o_gnt;
  logic [3:0] o_gnt_idx;
  logic       o_gnt_vld;
  logic       o_timeout;

  int nAsserts = 0;
  int nFails   = 0;

  rr_arb9_ctrl #(.NREQ(9), .MAX_HOLD(64)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .i_done    (i_done),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx),
    .o_gnt_vld (o_gnt_vld),
    .o_timeout (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs set here are sampled at the next rising edge; outputs are read 1 time unit later.
  task automatic applyStimulus(input logic rstN, input logic [8:0] req, input logic [8:0] done);
    i_rst_n = rstN;
    i_req   = req;
    i_done  = done;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expVld, input logic [3:0] expIdx,
                             input logic expTo);
    logic [8:0] expGnt;
    expGnt = expVld ? (9'b1 << expIdx) : 9'b0;
    nAsserts++;
    assert (o_gnt_vld === expVld) else begin
      nFails++;
      $error("[TB] FAIL %s vld: observed %b expected %b", tag, o_gnt_vld, expVld);
    end
    nAsserts++;
    assert (o_gnt_idx === expIdx) else begin
      nFails++;
      $error("[TB] FAIL %s idx: observed %0d expected %0d", tag, o_gnt_idx, expIdx);
    end
    nAsserts++;
    assert (o_gnt === expGnt) else begin
      nFails++;
      $error("[TB] FAIL %s gnt: observed %h expected %h", tag, o_gnt, expGnt);
    end
    nAsserts++;
    assert (o_timeout === expTo) else begin
      nFails++;
      $error("[TB] FAIL %s timeout: observed %b expected %b", tag, o_timeout, expTo);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = 9'h1FF;
    i_done  = 9'h000;

    applyStimulus(1'b0, 9'h1FF, 9'h000);
    checkOutput("reset1", 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 9'h1FF, 9'h000);
    checkOutput("reset2", 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 9'h1FF, 9'h000);
    checkOutput("first_after_reset", 1'b1, 4'd0, 1'b0);

    // Each owner finishes in its first cycle: rotation 1..8,0,1 with no bubbles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 9'h1FF, 9'b1 << (i % 9));
      checkOutput($sformatf("full_load_%0d", i), 1'b1, 4'((i + 1) % 9), 1'b0);
    end
    applyStimulus(1'b1, 9'h000, 9'h000);
    checkOutput("drop_all_idle", 1'b0, 4'd0, 1'b0);

    applyStimulus(1'b1, 9'h010, 9'h000);
    checkOutput("single_c1", 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b1, 9'h010, 9'h1EF);
    checkOutput("single_c2_foreign_done", 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b1, 9'h010, 9'h000);
    checkOutput("single_c3", 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b1, 9'h000, 9'h010);
    checkOutput("single_release", 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 9'h004, 9'h000);
    checkOutput("lone_req2", 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b1, 9'h000, 9'h004);
    checkOutput("req2_release", 1'b0, 4'd0, 1'b0);

    applyStimulus(1'b1, 9'h080, 9'h000);
    checkOutput("grant7", 1'b1, 4'd7, 1'b0);
    applyStimulus(1'b1, 9'h104, 9'h000);
    checkOutput("wrap_grant8", 1'b1, 4'd8, 1'b0);
    applyStimulus(1'b1, 9'h104, 9'h100);
    checkOutput("wrap_grant2", 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b1, 9'h000, 9'h004);
    checkOutput("wrap_idle", 1'b0, 4'd0, 1'b0);

    // Owner 8 releasing parks the pointer at 0 so index 0 wins the timeout test.
    applyStimulus(1'b1, 9'h100, 9'h000);
    checkOutput("grant8_again", 1'b1, 4'd8, 1'b0);
    applyStimulus(1'b1, 9'h000, 9'h100);
    checkOutput("ptr_to_0_idle", 1'b0, 4'd0, 1'b0);

    applyStimulus(1'b1, 9'h009, 9'h000);
    checkOutput("to_c1", 1'b1, 4'd0, 1'b0);
    for (int c = 2; c <= 64; c++) begin
      applyStimulus(1'b1, 9'h009, 9'h000);
      checkOutput($sformatf("to_hold_c%0d", c), 1'b1, 4'd0, 1'b0);
    end
    applyStimulus(1'b1, 9'h009, 9'h000);
    checkOutput("timeout_pulse", 1'b1, 4'd3, 1'b1);
    applyStimulus(1'b1, 9'h009, 9'h000);
    checkOutput("timeout_cleared", 1'b1, 4'd3, 1'b0);

    // Owner 3 now in cycle 2; hold to cycle 64, then done coincides with the budget.
    for (int c = 3; c <= 64; c++) begin
      applyStimulus(1'b1, 9'h009, 9'h000);
      checkOutput($sformatf("done64_hold_c%0d", c), 1'b1, 4'd3, 1'b0);
    end
    applyStimulus(1'b1, 9'h009, 9'h008);
    checkOutput("done_at_64_no_pulse", 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 9'h009, 9'h000);
    checkOutput("done_at_64_after", 1'b1, 4'd0, 1'b0);

    applyStimulus(1'b1, 9'h020, 9'h000);
    checkOutput("abort0_grant5", 1'b1, 4'd5, 1'b0);
    applyStimulus(1'b1, 9'h002, 9'h000);
    checkOutput("abort5_grant1", 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 9'h002, 9'h000);
    checkOutput("mid_grant_reset", 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 9'h1FF, 9'h000);
    checkOutput("post_reset_ptr0", 1'b1, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/rr_arb9_ctrl.md
# rr_arb9_ctrl

Round-robin arbiter and grant sequencer that shares one multi-port cache datapath among up to nine requesters. Each cycle it selects at most one requester, starting the search at a rotating pointer. It holds the grant until the owner signals completion, drops its request, or exceeds a hold-cycle budget. It sits in front of the shared port-select mux: `o_gnt_idx` drives the mux select, and `o_gnt_vld` qualifies it.

## Interface
- `NREQ`, default 9: number of requesters. Fixed at 9 for this block; the parameter exists for width derivation only.
- `MAX_HOLD`, default 64: maximum consecutive cycles one grant may be held. Must be ≥2.
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: reset, synchronous, active-low.
- `i_req`, input, `NREQ`: per-requester request level.
- `i_done`, input, `NREQ`: per-requester completion strobe. Only the bit of the current owner is observed.
- `o_gnt`, output, `NREQ`: one-hot grant, registered.
- `o_gnt_idx`, output, `$clog2(NREQ)` (4): index of the current owner, registered.
- `o_gnt_vld`, output, 1: grant valid, registered. It equals `|o_gnt`.
- `o_timeout`, output, 1: single-cycle pulse flagging a forced release.

## Operation
- State: `IDLE` (no owner) and `BUSY` (owner = `o_gnt_idx`). The block also holds pointer `ptr` (0..8) and hold counter `cnt` of width `$clog2(MAX_HOLD)`.
- Arbitration function: choose the first set bit of `i_req` searching `ptr`, `ptr+1`, …, 8, 0, …, `ptr-1`, with modulo-9 wrap and no index ≥9.
- `IDLE`: if `|i_req`, register the winner. `o_gnt`, `o_gnt_idx` and `o_gnt_vld` update at the next edge, `cnt` is set to 0, and the state moves to `BUSY`. Otherwise all grant outputs stay 0.
- `BUSY` release conditions, evaluated every cycle:
  - `i_done[idx]` = 1: normal release.
  - `i_req[idx]` = 0: abort, treated as a normal release.
  - `cnt` == `MAX_HOLD-1` with neither of the above: forced release. `o_timeout` = 1 in the next cycle.
- On release:
  - `ptr` is set to (`idx`+1) mod 9, so index 8 wraps to 0.
  - Arbitration is re-run in the same cycle using the updated pointer and the current `i_req`. The result is `i_req` with `i_req[idx]` masked off for abort and timeout, unmasked for done.
  - If there is a winner, the grant switches back-to-back at the next edge and `cnt` is set to 0.
  - If there is no winner, the grant outputs clear and the state moves to `IDLE`.
  - The old owner can be re-granted immediately after done only if no other requester is pending, because it is last in the search order.
- Without release: the grant is held and `cnt` increments.
- `i_done` bits other than the owner's, and any `i_done` in `IDLE`, are ignored.
- `i_done[idx]` asserted in the first grant cycle is legal and gives a 1-cycle grant.
- Done and timeout in the same cycle: done wins and `o_timeout` stays 0.
- Reset, including mid-grant: at the edge, `o_gnt`=0, `o_gnt_idx`=0, `o_gnt_vld`=0, `o_timeout`=0, `ptr`=0, `cnt`=0, state `IDLE`. The first arbitration after reset starts at index 0.

## Timing
- Request to grant: `i_req` sampled at edge k gives the grant visible in cycle k+1 (1-cycle latency).
- Release to next grant: the owner's done sampled at edge m gives the new owner visible in cycle m+1, with zero bubble cycles.
- Maximum grant length is `MAX_HOLD` cycles. `o_timeout` is high exactly in cycle `MAX_HOLD`+1 counted from the grant's first cycle.
- `o_gnt`, `o_gnt_idx` and `o_gnt_vld` change only at clock edges and are mutually consistent in every cycle.
- Fairness: with all 9 requesting continuously, each requester is granted exactly once per 9 grants.

## Test plan
- Reset: drive `i_rst_n`=0 for 2 cycles with `i_req`=9'h1FF → all outputs 0. First grant after release of reset goes to index 0.
- Single owner: `i_req`=9'h010, `i_done[4]` pulsed in the 3rd grant cycle → `o_gnt_idx`=4 for exactly 3 cycles, then `o_gnt_vld`=0. Next lone request on index 2 is granted, confirming `ptr` wrapped from 5.
- Full load: `i_req`=9'h1FF with each owner asserting done in its first grant cycle → back-to-back grant sequence 0,1,2,…,8,0,1 with no idle cycles.
- Wrap/priority: after index 7 releases (`ptr`=8), `i_req`=9'h104 → grant 8, then grant 2.
- Timeout: `MAX_HOLD`=64, `i_req`=9'h009, owner 0 never asserts done → grant 0 for 64 cycles, `o_timeout` pulse of 1 cycle, grant moves to 3 in the same cycle. A done coinciding with cycle 64 produces no pulse.
- Abort and mid-grant reset: owner 5 deasserts `i_req[5]` while 9'h002 is pending → grant moves to 1 next cycle. Asserting `i_rst_n`=0 during that grant → all outputs 0 at the next edge.
